shift_add_multiplier: RTL
=========================

// Module: shift_add_multiplier
// PURPOSE
//  Sequential unsigned 8x8 -> 16-bit multiplier built around the existing 8-bit
//  bidirectional barrel_shifter: one shift-and-add iteration per clock under a start/done handshake.
//  Sits downstream of operand registers. Feeds the ALU result mux.
//  Uses barrel_shifter as the multiplier-operand right-shift datapath.
// PARAMETERS
//  WIDTH    8    operand width; fixed at 8 to match barrel_shifter (in[7:0], shamt[2:0])
//  CNT_W    3    iteration counter width (log2 WIDTH)
// PORTS
//  clk      in   1    rising-edge clock
//  rst      in   1    synchronous, active-high reset
//  start    in   1    request; sampled only in IDLE or DONE
//  a        in   8    multiplicand, captured when start accepted
//  b        in   8    multiplier, captured when start accepted
//  busy     out  1    high while state==RUN
//  done     out  1    high for exactly one cycle (state==DONE)
//  product  out  16   a*b, registered; holds until next accepted start
// BEHAVIOUR
//  - Reset values: state=IDLE, busy=0, done=0, product=16'h0000, internal regs 0.
//  - rst wins over all other inputs, including mid-RUN; the in-flight result is discarded.
//  - FSM: IDLE -start-> RUN; RUN -term-> DONE; DONE -start-> RUN, else -> IDLE.
//  - start while in RUN is ignored; operands are not re-captured.
//  - On accept (edge E):
//    - mcand <= {8'h00,a}; mplier <= b; acc <= 0; cnt <= 0.
//  - Each RUN edge:
//    - if mplier[0], acc <= acc + mcand; 16-bit add, no carry-out (cannot overflow).
//    - mcand <= mcand << s; mplier <= barrel_shifter(mplier, shamt=s, dir=0).
//      dir=0 is a logical right shift with zero fill. s=1 by default.
//    - cnt <= cnt + 1.
//  - term (default): 8th RUN iteration (cnt==7). DONE is entered after edge E+8.
//  - Entering DONE: product <= final acc, including the last iteration's add.
//  - Latency: done observed in the cycle following edge E+N.
//    N=8 fixed by default; N is data dependent under ZERO_SKIP_EN.
// CONFIGURATION
//  ZERO_SKIP_EN defined:
//  - In RUN with mplier==0: go to DONE immediately; acc is unchanged.
//  - mplier[0]==0: s = trailing-zero count of mplier (1..7), no add.
//  - mplier[0]==1: add, s=1.
//  - term: shifted mplier==0, or mplier==0 on entry to RUN.
//  - Resulting N: b=0 -> 1, b=0x80 -> 2, b=0x05 -> 3, b=0xFF -> 8.
//  ZERO_SKIP_EN undefined:
//  - s is always 1 and N is always 8.
//  - Product is identical in both builds.
// STRUCTURE
//  - Package mul_pkg holds:
//    - state encodings S_IDLE=2'b00, S_RUN=2'b01, S_DONE=2'b10;
//    - WIDTH=8 and PROD_W=16 constants.
//  - One sub-module: existing barrel_shifter for the mplier shift, dir tied 0.
//  - Trailing-zero encoder and mcand shift are inline. There is no new sub-module.
// TESTING
//  1 rst held 2 cycles -> busy=0, done=0, product=0000; released with start=0 -> stays IDLE.
//  2 a=FF, b=FF, start -> product=FE01, done 1-cycle pulse, N=8 in both builds.
//  3 a=0D, b=0B -> product=008F. Default N=8; ZERO_SKIP_EN N=4.
//  4 a=37, b=00 -> product=0000. Default N=8; ZERO_SKIP_EN N=1.
//  5 a=03, b=80 -> product=0180. Default N=8; ZERO_SKIP_EN N=2.
//    Then start in the DONE cycle with a=02, b=02 -> accepted, product=0004.
//  6 a=FF, b=FF, start:
//    - start pulsed again with a=01 in RUN cycle 2 -> ignored, result stays FE01.
//    - separate run with rst asserted at RUN cycle 4 -> next cycle IDLE, busy=0, no done, product=0000.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared constants and FSM encoding for the sequential shift-and-add multiplier.
package mul_pkg;

    // Operand and product widths; WIDTH is fixed by the 8-bit barrel_shifter.
    localparam int unsigned WIDTH  = 8;
    localparam int unsigned PROD_W = 16;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/barrel_shifter.sv
// 8-bit bidirectional barrel shifter: dir=0 logical right, dir=1 logical left, zero fill.
module barrel_shifter (
    input  logic [7:0] in,
    input  logic [2:0] shamt,
    input  logic       dir,
    output logic [7:0] out
);

    // Pure combinational shift in the requested direction.
    always_comb begin
        out = 8'h00;
        if (dir) begin
            out = in << shamt;
        end else begin
            out = in >> shamt;
        end
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned 8x8 -> 16-bit shift-and-add multiplier, one iteration per clock,
// start/done handshake. The multiplier operand is shifted right through barrel_shifter.
// Optional build macro ZERO_SKIP_EN: skip runs of zero multiplier bits in one cycle and
// finish as soon as the remaining multiplier is zero.
module shift_add_multiplier
    import mul_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    output logic                busy,
    output logic                done,
    output logic [PROD_W-1:0]   product
);

    state_e              state_q, state_d;
    logic                accept;
    logic                term;
    logic [PROD_W-1:0]   mcand_q;
    logic [WIDTH-1:0]    mplier_q;
    logic [PROD_W-1:0]   acc_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [PROD_W-1:0]   product_q;
    logic [2:0]          shamt;
    logic [WIDTH-1:0]    mplier_shr;
    logic [PROD_W-1:0]   acc_sum;

    // Accumulate the shifted multiplicand when the current multiplier LSB is set.
    assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    barrel_shifter u_mplier_shifter (
        .in    (mplier_q),
        .shamt (shamt),
        .dir   (1'b0),
        .out   (mplier_shr)
    );

`ifdef ZERO_SKIP_EN
    // Shift amount is the trailing-zero count, or 1 after an add; finish when nothing is left.
    always_comb begin
        shamt = 3'd1;
        for (int i = WIDTH - 1; i >= 1; i--) begin
            if (mplier_q[i]) begin
                shamt = 3'(i);
            end
        end
        if (mplier_q[0]) begin
            shamt = 3'd1;
        end
        // A zero multiplier shifts to zero too, so this also covers mplier==0 on entry.
        term = (mplier_shr == '0);
    end
`else
    // Fixed one-bit step; finish on the eighth iteration.
    always_comb begin
        shamt = 3'd1;
        term  = (cnt_q == CNT_W'(WIDTH - 1));
    end
`endif

    // Next-state decode; start is only honoured outside RUN.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    accept  = 1'b1;
                end
            end
            S_RUN: begin
                if (term) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    accept  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath: load operands on accept, iterate in RUN, latch the product on the last step.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else if (accept) begin
            mcand_q  <= {{(PROD_W - WIDTH){1'b0}}, a};
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (state_q == S_RUN) begin
            acc_q    <= acc_sum;
            mcand_q  <= mcand_q << shamt;
            mplier_q <= mplier_shr;
            cnt_q    <= cnt_q + 1'b1;
            if (term) begin
                product_q <= acc_sum;
            end
        end
    end

    assign busy    = (state_q == S_RUN);
    assign done    = (state_q == S_DONE);
    assign product = product_q;

endmodule
